// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round scheduler:
//   - key length codes carried on keylen
//   - round counts Nr for each legal key length
//   - scheduler state encoding
//   - width of the round-key index
//   - nr_of(): maps a key length code to its round count
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int ROUND_W = 4;

   typedef logic [ROUND_W-1:0] round_t;

   localparam logic [1:0] KEYLEN_128 = 2'd0;
   localparam logic [1:0] KEYLEN_192 = 2'd1;
   localparam logic [1:0] KEYLEN_256 = 2'd2;
   localparam logic [1:0] KEYLEN_ILL = 2'd3;

   localparam round_t NR_128 = 4'd10;
   localparam round_t NR_192 = 4'd12;
   localparam round_t NR_256 = 4'd14;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KINIT = 3'd1,
      ST_KWAIT = 3'd2,
      ST_INIT  = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // The illegal code never reaches this lookup (it is rejected at key_init);
   // it falls back to the AES-128 count so the result is always in range.
   function automatic round_t nr_of(input logic [1:0] kl);
      round_t nr;
      case (kl)
         KEYLEN_128: nr = NR_128;
         KEYLEN_192: nr = NR_192;
         KEYLEN_256: nr = NR_256;
         default:    nr = NR_128;
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_round_ctr.sv
// -----------------------------------------------------------------------------
// aes_round_ctr
// Loadable 4-bit up/down round-key index counter with terminal match.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           load load_val as the new index (priority over step)
//   load_val       index loaded on load
//   load_term      terminal index that applies from the load onwards
//   step           advance one position towards term (up or down)
//   up             step direction: 1 = increment, 0 = decrement
//   term           terminal index used when not loading
//   count          registered current index
//   at_term        registered flag: count equals the terminal index
//   match_nxt      the index being written this cycle equals its terminal index
// The counter saturates at term: a step that would move past it is ignored,
// so the index never wraps.
// -----------------------------------------------------------------------------
module aes_round_ctr
   import aes_pkg::*;
(
   input  logic   clk,
   input  logic   reset_n,
   input  logic   load,
   input  round_t load_val,
   input  round_t load_term,
   input  logic   step,
   input  logic   up,
   input  round_t term,
   output round_t count,
   output logic   at_term,
   output logic   match_nxt
);

   round_t count_r;
   round_t count_nxt_s;
   round_t term_nxt_s;
   logic   at_term_r;
   logic   can_step_s;

   // Next index: load wins, otherwise step only while still short of term.
   always_comb begin
      count_nxt_s = count_r;
      term_nxt_s  = term;
      if (up) begin
         can_step_s = (count_r < term);
      end else begin
         can_step_s = (count_r > term);
      end
      if (load) begin
         count_nxt_s = load_val;
         term_nxt_s  = load_term;
      end else if (step && can_step_s) begin
         if (up) begin
            count_nxt_s = count_r + 4'd1;
         end else begin
            count_nxt_s = count_r - 4'd1;
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Index and terminal-match registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r   <= 4'd0;
         at_term_r <= 1'b0;
      end else begin
         count_r   <= count_nxt_s;
         at_term_r <= (count_nxt_s == term_nxt_s);
      end
   end

   assign count     = count_r;
   assign at_term   = at_term_r;
   assign match_nxt = (count_nxt_s == term_nxt_s);

endmodule

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
// Control FSM for an iterative AES core: sequences key expansion through the
// key memory and steps the cipher datapath through its rounds, arbitrating
// the shared S-box between the two.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   key_init/keylen request key expansion; keylen 0/1/2 = 128/192/256, 3 illegal
//   next/encdec     request one block; encdec 1 = encrypt, 0 = decrypt
//   ready           idle and able to accept a request
//   key_valid       expanded key complete
//   error           one-cycle pulse on a rejected request
//   km_init         one-cycle init pulse to the key memory
//   km_ready        key memory ready flag
//   round           round-key index to the key memory read port
//   sbox_sel        S-box owner: 0 = key memory, 1 = cipher datapath
//   dp_start        datapath loads the block and applies the first round key
//   dp_round_en     a round is pending in the datapath
//   dp_final        the pending round is the last one (no MixColumns)
//   dp_round_ack    datapath finished the pending round
//   result_valid    one-cycle pulse: block result available
// All outputs are registered; each is written with the value belonging to
// the state being entered, so outputs and state change on the same edge.
// -----------------------------------------------------------------------------
module aes_round_sched
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       key_init,
   input  logic [1:0] keylen,
   input  logic       next,
   input  logic       encdec,
   output logic       ready,
   output logic       key_valid,
   output logic       error,
   output logic       km_init,
   input  logic       km_ready,
   output logic [3:0] round,
   output logic       sbox_sel,
   output logic       dp_start,
   output logic       dp_round_en,
   output logic       dp_final,
   input  logic       dp_round_ack,
   output logic       result_valid
);

   state_t     state_r;
   state_t     state_nxt_s;
   logic       ready_r;
   logic       key_valid_r;
   logic       error_r;
   logic       km_init_r;
   logic       sbox_sel_r;
   logic       dp_start_r;
   logic       dp_round_en_r;
   logic       dp_final_r;
   logic       result_valid_r;
   logic [1:0] keylen_r;
   logic       encdec_r;
   logic       seen_low_r;

   logic       err_s;
   logic       kv_set_s;
   logic       kv_clr_s;
   logic       lat_key_s;
   logic       lat_enc_s;
   logic       ctr_load_s;
   round_t     ctr_load_val_s;
   round_t     ctr_load_term_s;
   logic       ctr_step_s;
   round_t     nr_s;
   round_t     term_s;
   round_t     ctr_count_s;
   logic       ctr_at_term_s;
   logic       ctr_match_nxt_s;

   assign nr_s   = nr_of(keylen_r);
   assign term_s = encdec_r ? nr_s : 4'd0;

   aes_round_ctr u_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ctr_load_s),
      .load_val  (ctr_load_val_s),
      .load_term (ctr_load_term_s),
      .step      (ctr_step_s),
      .up        (encdec_r),
      .term      (term_s),
      .count     (ctr_count_s),
      .at_term   (ctr_at_term_s),
      .match_nxt (ctr_match_nxt_s)
   );

   // Next-state and request decode. Requests are only honoured in IDLE once
   // ready is up, which also masks the first cycle after reset release.
   always_comb begin
      state_nxt_s     = state_r;
      err_s           = 1'b0;
      kv_set_s        = 1'b0;
      kv_clr_s        = 1'b0;
      lat_key_s       = 1'b0;
      lat_enc_s       = 1'b0;
      ctr_load_s      = 1'b0;
      ctr_load_val_s  = 4'd0;
      ctr_load_term_s = 4'd0;
      ctr_step_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ready_r && key_init) begin
               // key_init has priority; a simultaneous next is dropped silently
               if (keylen == KEYLEN_ILL) begin
                  err_s = 1'b1;
               end else begin
                  state_nxt_s = ST_KINIT;
                  kv_clr_s    = 1'b1;
                  lat_key_s   = 1'b1;
                  ctr_load_s  = 1'b1;   // new key: index restarts at 0
               end
            end else if (ready_r && next) begin
               if (key_valid_r) begin
                  state_nxt_s     = ST_INIT;
                  lat_enc_s       = 1'b1;
                  ctr_load_s      = 1'b1;
                  ctr_load_val_s  = encdec ? 4'd0 : nr_s;
                  ctr_load_term_s = encdec ? nr_s : 4'd0;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_KINIT: begin
            state_nxt_s = ST_KWAIT;
         end
         ST_KWAIT: begin
            // The key memory must drop ready first, so a stale high level
            // left over from before km_init cannot end the wait.
            if (km_ready && seen_low_r) begin
               state_nxt_s = ST_IDLE;
               kv_set_s    = 1'b1;
            end else begin
               state_nxt_s = ST_KWAIT;
            end
         end
         ST_INIT: begin
            state_nxt_s = ST_ROUND;
            ctr_step_s  = 1'b1;
         end
         ST_ROUND: begin
            if (dp_round_ack) begin
               if (ctr_at_term_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  ctr_step_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_ROUND;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, latched request fields and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         ready_r        <= 1'b0;
         key_valid_r    <= 1'b0;
         error_r        <= 1'b0;
         km_init_r      <= 1'b0;
         sbox_sel_r     <= 1'b0;
         dp_start_r     <= 1'b0;
         dp_round_en_r  <= 1'b0;
         dp_final_r     <= 1'b0;
         result_valid_r <= 1'b0;
         keylen_r       <= KEYLEN_128;
         encdec_r       <= 1'b0;
         seen_low_r     <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         ready_r        <= (state_nxt_s == ST_IDLE);
         error_r        <= err_s;
         km_init_r      <= (state_nxt_s == ST_KINIT);
         sbox_sel_r     <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_ROUND) ||
                           (state_nxt_s == ST_DONE);
         dp_start_r     <= (state_nxt_s == ST_INIT);
         dp_round_en_r  <= (state_nxt_s == ST_ROUND);
         dp_final_r     <= (state_nxt_s == ST_ROUND) && ctr_match_nxt_s;
         result_valid_r <= (state_nxt_s == ST_DONE);

         if (kv_clr_s) begin
            key_valid_r <= 1'b0;
         end else if (kv_set_s) begin
            key_valid_r <= 1'b1;
         end else begin
            key_valid_r <= key_valid_r;
         end

         if (lat_key_s) begin
            keylen_r <= keylen;
         end else begin
            keylen_r <= keylen_r;
         end

         if (lat_enc_s) begin
            encdec_r <= encdec;
         end else begin
            encdec_r <= encdec_r;
         end

         if (state_nxt_s == ST_KINIT) begin
            seen_low_r <= 1'b0;
         end else if ((state_r == ST_KWAIT) && !km_ready) begin
            seen_low_r <= 1'b1;
         end else begin
            seen_low_r <= seen_low_r;
         end
      end
   end

   assign ready        = ready_r;
   assign key_valid    = key_valid_r;
   assign error        = error_r;
   assign km_init      = km_init_r;
   assign round        = ctr_count_s;
   assign sbox_sel     = sbox_sel_r;
   assign dp_start     = dp_start_r;
   assign dp_round_en  = dp_round_en_r;
   assign dp_final     = dp_final_r;
   assign result_valid = result_valid_r;

endmodule

// File: tb/tb_aes_round_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sched
// Directed bench for aes_round_sched. Stimulus tasks state, cycle by cycle,
// what every output must be; a single negedge process compares all outputs
// against those expectations. Literal checks pin latencies, round sequences
// and pulse counts.
// -----------------------------------------------------------------------------
module tb_aes_round_sched;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       key_init;
   logic [1:0] keylen;
   logic       next;
   logic       encdec;
   logic       km_ready;
   logic       dp_round_ack;
   logic       ready, key_valid, error, km_init, sbox_sel;
   logic       dp_start, dp_round_en, dp_final, result_valid;
   logic [3:0] round;

   aes_round_sched dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_init     (key_init),
      .keylen       (keylen),
      .next         (next),
      .encdec       (encdec),
      .ready        (ready),
      .key_valid    (key_valid),
      .error        (error),
      .km_init      (km_init),
      .km_ready     (km_ready),
      .round        (round),
      .sbox_sel     (sbox_sel),
      .dp_start     (dp_start),
      .dp_round_en  (dp_round_en),
      .dp_final     (dp_final),
      .dp_round_ack (dp_round_ack),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rv_cnt = 0;
   int rv_cyc = 0;
   int kmi_cnt = 0;
   logic [3:0] seq[$];

   // expected outputs for the current cycle
   logic       e_ready, e_kv, e_err, e_kmi, e_sbox, e_start, e_ren, e_fin, e_rv;
   logic [3:0] e_round;
   bit         chk_en = 1'b0;

   // model of what IDLE must show
   logic       kv_m  = 1'b0;
   logic [3:0] rnd_m = 4'd0;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // per-cycle comparison of every output
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready",        {3'd0, ready},        {3'd0, e_ready});
         chk("key_valid",    {3'd0, key_valid},    {3'd0, e_kv});
         chk("error",        {3'd0, error},        {3'd0, e_err});
         chk("km_init",      {3'd0, km_init},      {3'd0, e_kmi});
         chk("sbox_sel",     {3'd0, sbox_sel},     {3'd0, e_sbox});
         chk("dp_start",     {3'd0, dp_start},     {3'd0, e_start});
         chk("dp_round_en",  {3'd0, dp_round_en},  {3'd0, e_ren});
         chk("dp_final",     {3'd0, dp_final},     {3'd0, e_fin});
         chk("result_valid", {3'd0, result_valid}, {3'd0, e_rv});
         chk("round",        round,                e_round);
      end
   end

   // event monitor for the literal checks
   always @(negedge clk) begin
      if (result_valid) begin
         rv_cnt++;
         rv_cyc = cyc;
      end
      if (km_init) kmi_cnt++;
      if (dp_start) begin
         seq.delete();
         seq.push_back(round);
      end else if (dp_round_en && seq.size() > 0 && seq[$] != round) begin
         seq.push_back(round);
      end
   end

   task automatic exp_clear();
      e_ready = 1'b0; e_kv = 1'b0; e_err = 1'b0; e_kmi = 1'b0; e_sbox = 1'b0;
      e_start = 1'b0; e_ren = 1'b0; e_fin = 1'b0; e_rv = 1'b0; e_round = 4'd0;
   endtask

   task automatic exp_idle();
      exp_clear();
      e_ready = 1'b1; e_kv = kv_m; e_round = rnd_m;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one rejected request: error for exactly one cycle, IDLE unchanged
   task automatic req_err(input logic ki, input logic [1:0] kl, input logic nx);
      key_init = ki; keylen = kl; next = nx;
      tick(); key_init = 1'b0; next = 1'b0; exp_idle(); e_err = 1'b1;
      tick(); exp_idle();
   endtask

   // key expansion; km_ready low for 'low' cycles; stray requests in KWAIT
   task automatic keyexp(input logic [1:0] kl, input int low, input logic with_next);
      key_init = 1'b1; keylen = kl; next = with_next; encdec = 1'b1;
      tick(); key_init = 1'b0; next = 1'b0; kv_m = 1'b0; rnd_m = 4'd0;
      exp_clear(); e_kmi = 1'b1;
      tick(); km_ready = 1'b0; exp_clear();
      for (int i = 1; i < low; i++) begin
         tick(); exp_clear();
         key_init = (i == 3); next = (i == 3);
      end
      tick(); key_init = 1'b0; next = 1'b0; km_ready = 1'b1; exp_clear();
      tick(); kv_m = 1'b1; exp_idle();
   endtask

   // one block; ack on the last of every 'per' cycles of a round;
   // abort_idx >= 0 asserts reset at the start of that round
   task automatic run_op(input logic enc, input int nr, input int per,
                         input int abort_idx, input int exp_lat);
      int idx;
      int c0;
      next = 1'b1; encdec = enc; c0 = cyc;
      tick(); next = 1'b0;
      exp_clear(); e_kv = 1'b1; e_sbox = 1'b1; e_start = 1'b1;
      e_round = enc ? 4'd0 : 4'(nr);
      idx = enc ? 1 : nr - 1;
      for (int r = 0; r < nr; r++) begin
         for (int w = 0; w < per; w++) begin
            tick();
            exp_clear(); e_kv = 1'b1; e_sbox = 1'b1; e_ren = 1'b1;
            e_round = 4'(idx); e_fin = (r == nr - 1);
            if (w == 0 && idx == abort_idx) begin
               reset_n = 1'b0; dp_round_ack = 1'b0;
               exp_clear(); kv_m = 1'b0; rnd_m = 4'd0;
               return;
            end
            dp_round_ack = (w == per - 1);
         end
         if (r != nr - 1) idx = enc ? idx + 1 : idx - 1;
      end
      tick(); dp_round_ack = 1'b0;
      exp_clear(); e_kv = 1'b1; e_sbox = 1'b1; e_rv = 1'b1; e_round = 4'(idx);
      tick(); rnd_m = 4'(idx); exp_idle();
      lit("latency", rv_cyc - c0, exp_lat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; key_init = 1'b0; keylen = 2'd0; next = 1'b0;
      encdec = 1'b0; km_ready = 1'b1; dp_round_ack = 1'b0;
      exp_clear();
      chk_en = 1'b1;

      // reset: all outputs low; ready one cycle after release
      tick(); tick();
      reset_n = 1'b1; exp_clear();
      tick(); exp_idle();
      tick();

      // rejected requests with no key
      req_err(1'b0, 2'd0, 1'b1);
      req_err(1'b1, 2'd3, 1'b0);
      lit("kv_after_err", int'(key_valid), 0);

      // AES-128 expansion, km_ready low for 12 cycles
      keyexp(2'd0, 12, 1'b0);
      lit("km_init_pulses", kmi_cnt, 1);
      lit("kv_after_exp", int'(key_valid), 1);

      // AES-128 encrypt, ack every cycle
      run_op(1'b1, 10, 1, -1, 12);
      lit("enc128_len", seq.size(), 11);
      lit("enc128_first", int'(seq[0]), 0);
      lit("enc128_last", int'(seq[10]), 10);

      // AES-256 expansion with next raised alongside key_init
      keyexp(2'd2, 5, 1'b1);
      lit("err_none", int'(error), 0);

      // AES-256 decrypt, ack every 4th cycle
      run_op(1'b0, 14, 4, -1, 58);
      lit("dec256_len", seq.size(), 15);
      lit("dec256_first", int'(seq[0]), 14);
      lit("dec256_last", int'(seq[14]), 0);

      // illegal keylen with a valid key keeps the key
      req_err(1'b1, 2'd3, 1'b0);

      // AES-192 encrypt, ack every 2nd cycle
      keyexp(2'd1, 3, 1'b0);
      run_op(1'b1, 12, 2, -1, 26);
      lit("enc192_last", int'(seq[12]), 12);

      // reset during ROUND at index 5
      keyexp(2'd0, 4, 1'b0);
      run_op(1'b1, 10, 1, 5, 0);
      tick(); reset_n = 1'b1; exp_clear();
      tick(); exp_idle();
      req_err(1'b0, 2'd0, 1'b1);
      lit("rv_total", rv_cnt, 3);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
